mem_bus_arbiter: RTL and testbench

Shares the single tagged memory port between the instruction cache (loads only) and the data cache (loads and stores). Each cycle it grants the port to one requester and passes the memory's same-cycle response tag back to the winner. It records which requester owns each outstanding load tag, so that returned data goes only to the requester that issued it. It sits between both caches and the memory interface at the processor top level.

---
 rtl/mem_bus_arbiter_if.sv | 44 ++++
 rtl/mem_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_if.sv
// Bundles the two cache request ports and the tagged memory port around mem_bus_arbiter.
// A requester presents a command and holds it until the accept tag it sees is nonzero; that tag is the only completion.
interface mem_bus_arbiter_if #(
    parameter int XLEN = 32
);
    logic [1:0]      icache2arb_command;
    logic [XLEN-1:0] icache2arb_addr;
    logic [1:0]      dcache2arb_command;
    logic [XLEN-1:0] dcache2arb_addr;
    logic [63:0]     dcache2arb_data;
    logic [3:0]      mem2arb_response;
    logic [63:0]     mem2arb_data;
    logic [3:0]      mem2arb_tag;

    logic [1:0]      arb2mem_command;
    logic [XLEN-1:0] arb2mem_addr;
    logic [63:0]     arb2mem_data;
    logic [3:0]      arb2icache_response;
    logic [63:0]     arb2icache_data;
    logic [3:0]      arb2icache_tag;
    logic [3:0]      arb2dcache_response;
    logic [63:0]     arb2dcache_data;
    logic [3:0]      arb2dcache_tag;

    // Arbiter side: owns the shared memory port and the per-cache return paths.
    modport master (
        input  icache2arb_command, icache2arb_addr,
        input  dcache2arb_command, dcache2arb_addr, dcache2arb_data,
        input  mem2arb_response, mem2arb_data, mem2arb_tag,
        output arb2mem_command, arb2mem_addr, arb2mem_data,
        output arb2icache_response, arb2icache_data, arb2icache_tag,
        output arb2dcache_response, arb2dcache_data, arb2dcache_tag
    );

    // Environment side: caches and memory.
    modport slave (
        output icache2arb_command, icache2arb_addr,
        output dcache2arb_command, dcache2arb_addr, dcache2arb_data,
        output mem2arb_response, mem2arb_data, mem2arb_tag,
        input  arb2mem_command, arb2mem_addr, arb2mem_data,
        input  arb2icache_response, arb2icache_data, arb2icache_tag,
        input  arb2dcache_response, arb2dcache_data, arb2dcache_tag
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one tagged memory port between icache (loads) and dcache (loads/stores), with
// starvation protection for icache and a per-tag owner table that routes returned data.
module mem_bus_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int NUM_TAGS     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    mem_bus_arbiter_if.master        bus,
    output logic [4:0]               outstanding_count,
    output logic                     tag_error,
    output logic [2:0]               starve_cnt
);
    localparam logic [1:0] BUS_NONE   = 2'd0;
    localparam logic [1:0] BUS_LOAD   = 2'd1;
    localparam logic [1:0] BUS_STORE  = 2'd2;
    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic                icache_req;
    logic                dcache_req;
    logic                grant_icache;
    logic                grant_dcache;
    logic                ret_present;
    logic                ret_hit;
    logic                ret_owner;
    logic                alloc_en;
    logic                alloc_owner;

    logic [NUM_TAGS-1:0] valid_q;
    logic [NUM_TAGS-1:0] valid_d;
    logic [NUM_TAGS-1:0] owner_q;
    logic [NUM_TAGS-1:0] owner_d;
    logic [2:0]          starve_d;
    logic                tag_error_d;
    logic [4:0]          count_d;

    // Request decode and grant; icache STORE is not a legal request and reads as idle.
    always_comb begin
        icache_req   = 1'b0;
        dcache_req   = 1'b0;
        grant_icache = 1'b0;
        grant_dcache = 1'b0;
        if (!reset) begin
            icache_req   = (bus.icache2arb_command == BUS_LOAD);
            dcache_req   = (bus.dcache2arb_command == BUS_LOAD) ||
                           (bus.dcache2arb_command == BUS_STORE);
            grant_icache = icache_req && (!dcache_req || (starve_cnt == STARVE_MAX));
            grant_dcache = dcache_req && !grant_icache;
        end
    end

    always_comb begin
        bus.arb2mem_command     = BUS_NONE;
        bus.arb2mem_addr        = '0;
        bus.arb2mem_data        = '0;
        bus.arb2icache_response = '0;
        bus.arb2dcache_response = '0;
        if (grant_icache) begin
            bus.arb2mem_command     = BUS_LOAD;
            bus.arb2mem_addr        = bus.icache2arb_addr;
            bus.arb2icache_response = bus.mem2arb_response;
        end else if (grant_dcache) begin
            bus.arb2mem_command     = bus.dcache2arb_command;
            bus.arb2mem_addr        = bus.dcache2arb_addr;
            bus.arb2mem_data        = bus.dcache2arb_data;
            bus.arb2dcache_response = bus.mem2arb_response;
        end
    end

    // Return lookup uses the owner as it stands before this cycle's allocation.
    always_comb begin
        ret_present = !reset && (bus.mem2arb_tag != 4'd0);
        ret_hit     = ret_present && valid_q[bus.mem2arb_tag];
        ret_owner   = owner_q[bus.mem2arb_tag];
        alloc_en    = (grant_icache ||
                       (grant_dcache && (bus.dcache2arb_command == BUS_LOAD))) &&
                      (bus.mem2arb_response != 4'd0);
        alloc_owner = grant_dcache;
    end

    always_comb begin
        bus.arb2icache_tag  = '0;
        bus.arb2icache_data = '0;
        bus.arb2dcache_tag  = '0;
        bus.arb2dcache_data = '0;
        if (ret_hit && !ret_owner) begin
            bus.arb2icache_tag  = bus.mem2arb_tag;
            bus.arb2icache_data = bus.mem2arb_data;
        end
        if (ret_hit && ret_owner) begin
            bus.arb2dcache_tag  = bus.mem2arb_tag;
            bus.arb2dcache_data = bus.mem2arb_data;
        end
    end

    // Retire first, then allocate, so a same-tag reuse ends valid under the new owner.
    always_comb begin
        valid_d     = valid_q;
        owner_d     = owner_q;
        starve_d    = 3'd0;
        tag_error_d = tag_error || (ret_present && !ret_hit);
        if (ret_hit) begin
            valid_d[bus.mem2arb_tag] = 1'b0;
        end
        if (alloc_en) begin
            valid_d[bus.mem2arb_response] = 1'b1;
            owner_d[bus.mem2arb_response] = alloc_owner;
        end
        if (icache_req && !grant_icache) begin
            starve_d = (starve_cnt >= STARVE_MAX) ? STARVE_MAX : starve_cnt + 3'd1;
        end
        count_d = 5'($countones(valid_d));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q           <= '0;
            owner_q           <= '0;
            starve_cnt        <= 3'd0;
            tag_error         <= 1'b0;
            outstanding_count <= 5'd0;
        end else begin
            valid_q           <= valid_d;
            owner_q           <= owner_d;
            starve_cnt        <= starve_d;
            tag_error         <= tag_error_d;
            outstanding_count <= count_d;
        end
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: the bench plays both caches and the memory,
// keeps its own tag-ownership model and checks routing through an expected-return queue.
module tb_mem_bus_arbiter;
    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;
    localparam logic [1:0] BUS_STORE = 2'd2;
    localparam int XLEN = 32;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] outstanding_count;
    logic       tag_error;
    logic [2:0] starve_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected return: {dest (0 none, 1 icache, 2 dcache), tag, data}
    logic [69:0] exp_q[$];
    bit          tb_valid[16];
    bit          tb_owner[16];

    mem_bus_arbiter_if #(.XLEN(XLEN)) bus();

    mem_bus_arbiter #(
        .STARVE_LIMIT(4),
        .NUM_TAGS(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus.master),
        .outstanding_count(outstanding_count),
        .tag_error(tag_error),
        .starve_cnt(starve_cnt)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.icache2arb_command = BUS_NONE;
        bus.icache2arb_addr    = '0;
        bus.dcache2arb_command = BUS_NONE;
        bus.dcache2arb_addr    = '0;
        bus.dcache2arb_data    = '0;
        bus.mem2arb_response   = '0;
        bus.mem2arb_data       = '0;
        bus.mem2arb_tag        = '0;
    endtask

    task automatic model_alloc(input logic [3:0] tag, input bit owner);
        tb_valid[tag] = 1'b1;
        tb_owner[tag] = owner;
    endtask

    function automatic logic [4:0] model_count();
        logic [4:0] c = 5'd0;
        for (int i = 1; i < 16; i++) c = c + 5'(tb_valid[i]);
        return c;
    endfunction

    task automatic drive_return(input logic [3:0] tag, input logic [63:0] data);
        logic [1:0] dest;
        dest = tb_valid[tag] ? (tb_owner[tag] ? 2'd2 : 2'd1) : 2'd0;
        exp_q.push_back({dest, tag, data});
        tb_valid[tag] = 1'b0;
        bus.mem2arb_tag  = tag;
        bus.mem2arb_data = data;
    endtask

    function automatic logic [67:0] exp_side(input logic [69:0] e, input logic [1:0] who);
        return (e[69:68] == who) ? e[67:0] : 68'd0;
    endfunction

    task automatic test_reset();
        logic [69:0] e;
        bus.icache2arb_command = BUS_LOAD;
        bus.icache2arb_addr    = 32'h40;
        bus.dcache2arb_command = BUS_LOAD;
        bus.dcache2arb_addr    = 32'h80;
        bus.mem2arb_response   = 4'd5;
        bus.mem2arb_tag        = 4'd3;
        bus.mem2arb_data       = 64'h1234;
        #1;
        n_checks++; if (bus.arb2mem_command !== BUS_NONE) begin n_fail++; $display("FAIL rst_cmd: got %0d want 0", bus.arb2mem_command); end
        n_checks++; if ({bus.arb2mem_addr, bus.arb2mem_data} !== 96'd0) begin n_fail++; $display("FAIL rst_addr_data: got %h/%h want 0", bus.arb2mem_addr, bus.arb2mem_data); end
        n_checks++; if ({bus.arb2icache_response, bus.arb2dcache_response} !== 8'd0) begin n_fail++; $display("FAIL rst_resp: got %h want 0", {bus.arb2icache_response, bus.arb2dcache_response}); end
        n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data, bus.arb2dcache_tag, bus.arb2dcache_data} !== 136'd0) begin n_fail++; $display("FAIL rst_ret: returns not zero during reset"); end
        n_checks++; if ({outstanding_count, tag_error, starve_cnt} !== 9'd0) begin n_fail++; $display("FAIL rst_state: got cnt=%0d err=%0d starve=%0d want 0", outstanding_count, tag_error, starve_cnt); end
        cycle();
        n_checks++; if ({outstanding_count, tag_error, starve_cnt} !== 9'd0) begin n_fail++; $display("FAIL rst_hold: got cnt=%0d err=%0d starve=%0d want 0", outstanding_count, tag_error, starve_cnt); end
        drive_idle();
        reset = 1'b0;
        cycle();
    endtask

    task automatic test_solo_icache();
        logic [69:0] e;
        bus.icache2arb_command = BUS_LOAD;
        bus.icache2arb_addr    = 32'h100;
        bus.mem2arb_response   = 4'd3;
        #1;
        n_checks++; if (bus.arb2mem_command !== BUS_LOAD) begin n_fail++; $display("FAIL solo_cmd: got %0d want 1", bus.arb2mem_command); end
        n_checks++; if (bus.arb2mem_addr !== 32'h100) begin n_fail++; $display("FAIL solo_addr: got %h want 100", bus.arb2mem_addr); end
        n_checks++; if (bus.arb2mem_data !== 64'd0) begin n_fail++; $display("FAIL solo_data: got %h want 0", bus.arb2mem_data); end
        n_checks++; if ({bus.arb2icache_response, bus.arb2dcache_response} !== {4'd3, 4'd0}) begin n_fail++; $display("FAIL solo_resp: got %h want 30", {bus.arb2icache_response, bus.arb2dcache_response}); end
        model_alloc(4'd3, 1'b0);
        cycle();
        drive_idle();
        n_checks++; if (outstanding_count !== 5'd1) begin n_fail++; $display("FAIL solo_cnt1: got %0d want 1", outstanding_count); end
        cycle();
        drive_return(4'd3, 64'hDEAD);
        #1;
        e = exp_q.pop_front();
        n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data} !== exp_side(e, 2'd1)) begin n_fail++; $display("FAIL solo_ret_i: got %h want %h", {bus.arb2icache_tag, bus.arb2icache_data}, exp_side(e, 2'd1)); end
        n_checks++; if ({bus.arb2dcache_tag, bus.arb2dcache_data} !== exp_side(e, 2'd2)) begin n_fail++; $display("FAIL solo_ret_d: got %h want %h", {bus.arb2dcache_tag, bus.arb2dcache_data}, exp_side(e, 2'd2)); end
        cycle();
        drive_idle();
        n_checks++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL solo_cnt0: got %0d want 0", outstanding_count); end
    endtask

    task automatic test_contention();
        logic [69:0] e;
        logic [3:0]  r;
        bit          win_i;
        bus.icache2arb_command = BUS_LOAD;
        bus.icache2arb_addr    = 32'h1000;
        bus.dcache2arb_command = BUS_LOAD;
        bus.dcache2arb_addr    = 32'h2000;
        for (int c = 0; c < 10; c++) begin
            r = 4'(c + 1);
            bus.mem2arb_response = r;
            win_i = ((c % 5) == 4);
            #1;
            n_checks++; if (bus.arb2mem_addr !== (win_i ? 32'h1000 : 32'h2000)) begin n_fail++; $display("FAIL cont_addr[%0d]: got %h want %h", c, bus.arb2mem_addr, win_i ? 32'h1000 : 32'h2000); end
            n_checks++; if ({bus.arb2icache_response, bus.arb2dcache_response} !== (win_i ? {r, 4'd0} : {4'd0, r})) begin n_fail++; $display("FAIL cont_resp[%0d]: got %h want %h", c, {bus.arb2icache_response, bus.arb2dcache_response}, win_i ? {r, 4'd0} : {4'd0, r}); end
            model_alloc(r, !win_i);
            cycle();
            n_checks++; if (starve_cnt !== (win_i ? 3'd0 : 3'((c % 5) + 1))) begin n_fail++; $display("FAIL cont_starve[%0d]: got %0d want %0d", c, starve_cnt, win_i ? 0 : (c % 5) + 1); end
        end
        drive_idle();
        n_checks++; if (outstanding_count !== model_count()) begin n_fail++; $display("FAIL cont_cnt: got %0d want %0d", outstanding_count, model_count()); end
        for (int t = 1; t < 16; t++) begin
            if (tb_valid[t]) begin
                drive_return(4'(t), {32'hC0DE0000, 32'($urandom_range(0, 65535))});
                #1;
                e = exp_q.pop_front();
                n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data} !== exp_side(e, 2'd1)) begin n_fail++; $display("FAIL drain_i[%0d]: got %h want %h", t, {bus.arb2icache_tag, bus.arb2icache_data}, exp_side(e, 2'd1)); end
                n_checks++; if ({bus.arb2dcache_tag, bus.arb2dcache_data} !== exp_side(e, 2'd2)) begin n_fail++; $display("FAIL drain_d[%0d]: got %h want %h", t, {bus.arb2dcache_tag, bus.arb2dcache_data}, exp_side(e, 2'd2)); end
                cycle();
            end
        end
        drive_idle();
        n_checks++; if ({outstanding_count, tag_error} !== 6'd0) begin n_fail++; $display("FAIL drain_end: got cnt=%0d err=%0d want 0", outstanding_count, tag_error); end
    endtask

    task automatic test_store();
        bus.dcache2arb_command = BUS_STORE;
        bus.dcache2arb_addr    = 32'h200;
        bus.dcache2arb_data    = 64'h55;
        bus.mem2arb_response   = 4'd7;
        #1;
        n_checks++; if (bus.arb2mem_command !== BUS_STORE) begin n_fail++; $display("FAIL st_cmd: got %0d want 2", bus.arb2mem_command); end
        n_checks++; if ({bus.arb2mem_addr, bus.arb2mem_data} !== {32'h200, 64'h55}) begin n_fail++; $display("FAIL st_addr_data: got %h/%h want 200/55", bus.arb2mem_addr, bus.arb2mem_data); end
        n_checks++; if ({bus.arb2icache_response, bus.arb2dcache_response} !== {4'd0, 4'd7}) begin n_fail++; $display("FAIL st_resp: got %h want 07", {bus.arb2icache_response, bus.arb2dcache_response}); end
        cycle();
        drive_idle();
        n_checks++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL st_cnt: got %0d want 0", outstanding_count); end
        bus.icache2arb_command = BUS_STORE;
        bus.icache2arb_addr    = 32'h300;
        bus.mem2arb_response   = 4'd9;
        #1;
        n_checks++; if ({bus.arb2mem_command, bus.arb2mem_addr} !== {BUS_NONE, 32'h0}) begin n_fail++; $display("FAIL istore_cmd: got %0d/%h want 0/0", bus.arb2mem_command, bus.arb2mem_addr); end
        n_checks++; if (bus.arb2icache_response !== 4'd0) begin n_fail++; $display("FAIL istore_resp: got %0d want 0", bus.arb2icache_response); end
        cycle();
        drive_idle();
        n_checks++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL istore_cnt: got %0d want 0", outstanding_count); end
    endtask

    task automatic test_interleaved();
        logic [69:0] e;
        bus.icache2arb_command = BUS_LOAD;
        bus.icache2arb_addr    = 32'h110;
        bus.mem2arb_response   = 4'd2;
        #1;
        n_checks++; if (bus.arb2icache_response !== 4'd2) begin n_fail++; $display("FAIL il_resp_i: got %0d want 2", bus.arb2icache_response); end
        model_alloc(4'd2, 1'b0);
        cycle();
        drive_idle();
        bus.dcache2arb_command = BUS_LOAD;
        bus.dcache2arb_addr    = 32'h210;
        bus.mem2arb_response   = 4'd5;
        #1;
        n_checks++; if (bus.arb2dcache_response !== 4'd5) begin n_fail++; $display("FAIL il_resp_d: got %0d want 5", bus.arb2dcache_response); end
        model_alloc(4'd5, 1'b1);
        cycle();
        drive_idle();
        n_checks++; if (outstanding_count !== 5'd2) begin n_fail++; $display("FAIL il_cnt2: got %0d want 2", outstanding_count); end
        drive_return(4'd5, 64'hD5D5_0000_0000_D5D5);
        #1;
        e = exp_q.pop_front();
        n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data} !== exp_side(e, 2'd1)) begin n_fail++; $display("FAIL il_ret5_i: got %h want %h", {bus.arb2icache_tag, bus.arb2icache_data}, exp_side(e, 2'd1)); end
        n_checks++; if ({bus.arb2dcache_tag, bus.arb2dcache_data} !== exp_side(e, 2'd2)) begin n_fail++; $display("FAIL il_ret5_d: got %h want %h", {bus.arb2dcache_tag, bus.arb2dcache_data}, exp_side(e, 2'd2)); end
        cycle();
        drive_idle();
        drive_return(4'd2, 64'h1212_3434);
        #1;
        e = exp_q.pop_front();
        n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data} !== exp_side(e, 2'd1)) begin n_fail++; $display("FAIL il_ret2_i: got %h want %h", {bus.arb2icache_tag, bus.arb2icache_data}, exp_side(e, 2'd1)); end
        n_checks++; if ({bus.arb2dcache_tag, bus.arb2dcache_data} !== exp_side(e, 2'd2)) begin n_fail++; $display("FAIL il_ret2_d: got %h want %h", {bus.arb2dcache_tag, bus.arb2dcache_data}, exp_side(e, 2'd2)); end
        cycle();
        drive_idle();
        n_checks++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL il_cnt0: got %0d want 0", outstanding_count); end
    endtask

    task automatic test_same_tag();
        logic [69:0] e;
        bus.icache2arb_command = BUS_LOAD;
        bus.icache2arb_addr    = 32'h140;
        bus.mem2arb_response   = 4'd4;
        #1;
        n_checks++; if (bus.arb2icache_response !== 4'd4) begin n_fail++; $display("FAIL reuse_resp_i: got %0d want 4", bus.arb2icache_response); end
        model_alloc(4'd4, 1'b0);
        cycle();
        drive_idle();
        drive_return(4'd4, 64'hAAAA_4444);
        bus.dcache2arb_command = BUS_LOAD;
        bus.dcache2arb_addr    = 32'h240;
        bus.mem2arb_response   = 4'd4;
        #1;
        e = exp_q.pop_front();
        n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data} !== exp_side(e, 2'd1)) begin n_fail++; $display("FAIL reuse_ret_i: got %h want %h", {bus.arb2icache_tag, bus.arb2icache_data}, exp_side(e, 2'd1)); end
        n_checks++; if ({bus.arb2dcache_tag, bus.arb2dcache_data} !== exp_side(e, 2'd2)) begin n_fail++; $display("FAIL reuse_ret_d: got %h want %h", {bus.arb2dcache_tag, bus.arb2dcache_data}, exp_side(e, 2'd2)); end
        n_checks++; if (bus.arb2dcache_response !== 4'd4) begin n_fail++; $display("FAIL reuse_resp_d: got %0d want 4", bus.arb2dcache_response); end
        model_alloc(4'd4, 1'b1);
        cycle();
        drive_idle();
        n_checks++; if (outstanding_count !== 5'd1) begin n_fail++; $display("FAIL reuse_cnt1: got %0d want 1", outstanding_count); end
        drive_return(4'd4, 64'hBBBB_4444);
        #1;
        e = exp_q.pop_front();
        n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data} !== exp_side(e, 2'd1)) begin n_fail++; $display("FAIL reuse2_i: got %h want %h", {bus.arb2icache_tag, bus.arb2icache_data}, exp_side(e, 2'd1)); end
        n_checks++; if ({bus.arb2dcache_tag, bus.arb2dcache_data} !== exp_side(e, 2'd2)) begin n_fail++; $display("FAIL reuse2_d: got %h want %h", {bus.arb2dcache_tag, bus.arb2dcache_data}, exp_side(e, 2'd2)); end
        cycle();
        drive_idle();
        n_checks++; if ({outstanding_count, tag_error} !== 6'd0) begin n_fail++; $display("FAIL reuse_end: got cnt=%0d err=%0d want 0", outstanding_count, tag_error); end
    endtask

    task automatic test_reset_mid();
        logic [69:0] e;
        for (int i = 1; i <= 3; i++) begin
            if (i == 2) begin
                bus.dcache2arb_command = BUS_LOAD;
                bus.dcache2arb_addr    = 32'h300;
            end else begin
                bus.icache2arb_command = BUS_LOAD;
                bus.icache2arb_addr    = 32'(32'h400 + i);
            end
            bus.mem2arb_response = 4'(i);
            model_alloc(4'(i), i == 2);
            cycle();
            drive_idle();
        end
        n_checks++; if ({outstanding_count, tag_error} !== {5'd3, 1'b0}) begin n_fail++; $display("FAIL rm_cnt3: got cnt=%0d err=%0d want 3/0", outstanding_count, tag_error); end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int t = 0; t < 16; t++) tb_valid[t] = 1'b0;
        n_checks++; if (outstanding_count !== 5'd0) begin n_fail++; $display("FAIL rm_cnt_rst: got %0d want 0", outstanding_count); end
        drive_return(4'd1, 64'hF00D);
        #1;
        e = exp_q.pop_front();
        n_checks++; if ({bus.arb2icache_tag, bus.arb2icache_data} !== exp_side(e, 2'd1)) begin n_fail++; $display("FAIL rm_ret_i: got %h want %h", {bus.arb2icache_tag, bus.arb2icache_data}, exp_side(e, 2'd1)); end
        n_checks++; if ({bus.arb2dcache_tag, bus.arb2dcache_data} !== exp_side(e, 2'd2)) begin n_fail++; $display("FAIL rm_ret_d: got %h want %h", {bus.arb2dcache_tag, bus.arb2dcache_data}, exp_side(e, 2'd2)); end
        cycle();
        drive_idle();
        n_checks++; if ({outstanding_count, tag_error} !== {5'd0, 1'b1}) begin n_fail++; $display("FAIL rm_err: got cnt=%0d err=%0d want 0/1", outstanding_count, tag_error); end
        cycle();
        n_checks++; if (tag_error !== 1'b1) begin n_fail++; $display("FAIL rm_sticky: got %0d want 1", tag_error); end
    endtask

    initial begin
        drive_idle();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        test_reset();
        test_solo_icache();
        test_contention();
        test_store();
        test_interleaved();
        test_same_tag();
        test_reset_mid();
        n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL exp_q_left: got %0d want 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
